// File: rtl/reorder_buffer_retire_ctrl_pkg.sv
// Shared widths, FSM state encodings and retire-width codes for the ROB commit stage.
package reorder_buffer_retire_ctrl_pkg;

    localparam int TAG_BITS_SIZE = 4;
    localparam int REG_ADDR_BITS = 4;
    localparam int DATA_WIDTH    = 32;
    localparam int PC_WIDTH      = 32;
    localparam int COUNT_WIDTH   = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } retire_state_e;

    typedef enum logic [1:0] {
        RW_NONE = 2'd0,
        RW_ONE  = 2'd1,
        RW_TWO  = 2'd2
    } retire_width_e;

    // Retired-instruction counter advance; wraps modulo 2**32.
    function automatic logic [COUNT_WIDTH-1:0] rob_count_next(
        input logic [COUNT_WIDTH-1:0] count,
        input logic [1:0]             inc
    );
        return count + {{(COUNT_WIDTH-2){1'b0}}, inc};
    endfunction

endpackage

// File: rtl/reorder_buffer_retire_ctrl_if.sv
// ROB head view plus retire outputs (shift pulses, RF write ports, flush/redirect).
interface reorder_buffer_retire_ctrl_if
    import reorder_buffer_retire_ctrl_pkg::*;
#(
    parameter int TAG_W  = TAG_BITS_SIZE,
    parameter int ADDR_W = REG_ADDR_BITS,
    parameter int DATA_W = DATA_WIDTH,
    parameter int PC_W   = PC_WIDTH
);
    logic [TAG_W-1:0]       rob_status_in;

    logic                   head0_ready_in;
    logic                   head0_dest_valid_in;
    logic                   head0_exception_in;
    logic                   head0_mispredict_in;
    logic [ADDR_W-1:0]      head0_dest_in;
    logic [DATA_W-1:0]      head0_data_in;
    logic [PC_W-1:0]        head0_pc_in;
    logic [PC_W-1:0]        head0_target_in;

    logic                   head1_ready_in;
    logic                   head1_dest_valid_in;
    logic                   head1_exception_in;
    logic                   head1_mispredict_in;
    logic [ADDR_W-1:0]      head1_dest_in;
    logic [DATA_W-1:0]      head1_data_in;
    logic [PC_W-1:0]        head1_pc_in;
    logic [PC_W-1:0]        head1_target_in;

    logic                   reorder_buffer_shift_out;
    logic                   reorder_buffer_shift_2_out;
    logic                   rf_we0_out;
    logic                   rf_we1_out;
    logic [ADDR_W-1:0]      rf_addr0_out;
    logic [ADDR_W-1:0]      rf_addr1_out;
    logic [DATA_W-1:0]      rf_data0_out;
    logic [DATA_W-1:0]      rf_data1_out;
    logic                   flush_out;
    logic [PC_W-1:0]        redirect_pc_out;
    logic                   exception_out;
    logic [31:0]            retire_count_out;

    modport slave (
        input  rob_status_in,
        input  head0_ready_in, head0_dest_valid_in, head0_exception_in, head0_mispredict_in,
        input  head0_dest_in, head0_data_in, head0_pc_in, head0_target_in,
        input  head1_ready_in, head1_dest_valid_in, head1_exception_in, head1_mispredict_in,
        input  head1_dest_in, head1_data_in, head1_pc_in, head1_target_in,
        output reorder_buffer_shift_out, reorder_buffer_shift_2_out,
        output rf_we0_out, rf_we1_out, rf_addr0_out, rf_addr1_out, rf_data0_out, rf_data1_out,
        output flush_out, redirect_pc_out, exception_out, retire_count_out
    );

    modport master (
        output rob_status_in,
        output head0_ready_in, head0_dest_valid_in, head0_exception_in, head0_mispredict_in,
        output head0_dest_in, head0_data_in, head0_pc_in, head0_target_in,
        output head1_ready_in, head1_dest_valid_in, head1_exception_in, head1_mispredict_in,
        output head1_dest_in, head1_data_in, head1_pc_in, head1_target_in,
        input  reorder_buffer_shift_out, reorder_buffer_shift_2_out,
        input  rf_we0_out, rf_we1_out, rf_addr0_out, rf_addr1_out, rf_data0_out, rf_data1_out,
        input  flush_out, redirect_pc_out, exception_out, retire_count_out
    );

endinterface

// File: rtl/reorder_buffer_retire_ctrl_select.sv
// Combinational eligibility and retire-width decision for the two oldest ROB entries.
module reorder_buffer_retire_select
    import reorder_buffer_retire_ctrl_pkg::*;
#(
    parameter int TAG_W = TAG_BITS_SIZE
) (
    input  logic [TAG_W-1:0] i_rob_status,
    input  logic             i_head0_ready,
    input  logic             i_head0_exception,
    input  logic             i_head0_mispredict,
    input  logic             i_head1_ready,
    input  logic             i_head1_exception,
    input  logic             i_head1_mispredict,
    output logic             o_e0,
    output logic             o_e1,
    output logic             o_head0_fault,
    output retire_width_e    o_width
);
    logic w_status_ge1;
    logic w_status_ge2;
    logic w_head1_fault;

    assign w_status_ge1  = (i_rob_status != '0);
    assign w_status_ge2  = (i_rob_status > TAG_W'(1));
    assign o_head0_fault = i_head0_exception | i_head0_mispredict;
    assign w_head1_fault = i_head1_exception | i_head1_mispredict;

    assign o_e0 = w_status_ge1 & i_head0_ready;
    assign o_e1 = o_e0 & w_status_ge2 & i_head1_ready & ~o_head0_fault;

    // A faulting head1 still lets head0 retire alone; it reaches head0 next decision.
    always_comb begin
        o_width = RW_NONE;
        if (o_e0) begin
            if (o_head0_fault) begin
                o_width = RW_ONE;
            end else if (o_e1 && !w_head1_fault) begin
                o_width = RW_TWO;
            end else begin
                o_width = RW_ONE;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_retire_ctrl.sv
// In-order commit at the ROB head: retires 0/1/2 entries, writes the RF, flushes on faults.
//   state    | meaning
//   ST_RUN   | inspect head0/head1 and retire up to two
//   ST_WAIT  | one bubble while the ROB shifts
//   ST_FLUSH | flush issued; hold until the ROB reports empty
module reorder_buffer_retire_ctrl
    import reorder_buffer_retire_ctrl_pkg::*;
#(
    parameter int TAG_W  = TAG_BITS_SIZE,
    parameter int ADDR_W = REG_ADDR_BITS,
    parameter int DATA_W = DATA_WIDTH,
    parameter int PC_W   = PC_WIDTH
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    reorder_buffer_retire_ctrl_if.slave  rob
);
    retire_state_e      r_state;
    retire_state_e      w_state_next;

    logic               r_shift, r_shift_2, r_we0, r_we1, r_flush, r_exception;
    logic [ADDR_W-1:0]  r_addr0, r_addr1;
    logic [DATA_W-1:0]  r_data0, r_data1;
    logic [PC_W-1:0]    r_redirect;
    logic [COUNT_WIDTH-1:0] r_count;

    logic               w_shift, w_shift_2, w_we0, w_we1, w_flush, w_exception;
    logic [ADDR_W-1:0]  w_addr0, w_addr1;
    logic [DATA_W-1:0]  w_data0, w_data1;
    logic [PC_W-1:0]    w_redirect;
    logic [COUNT_WIDTH-1:0] w_count_next;

    logic               w_e0, w_e1, w_head0_fault;
    retire_width_e      w_width;
    logic               w_unused_fields;

    // Exceptions vector to 0, so the PCs and head1's target are never needed here.
    assign w_unused_fields = ^{rob.head0_pc_in, rob.head1_pc_in, rob.head1_target_in, w_e1};

    reorder_buffer_retire_select #(
        .TAG_W (TAG_W)
    ) u_select (
        .i_rob_status       (rob.rob_status_in),
        .i_head0_ready      (rob.head0_ready_in),
        .i_head0_exception  (rob.head0_exception_in),
        .i_head0_mispredict (rob.head0_mispredict_in),
        .i_head1_ready      (rob.head1_ready_in),
        .i_head1_exception  (rob.head1_exception_in),
        .i_head1_mispredict (rob.head1_mispredict_in),
        .o_e0               (w_e0),
        .o_e1               (w_e1),
        .o_head0_fault      (w_head0_fault),
        .o_width            (w_width)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state     <= ST_RUN;
            r_shift     <= 1'b0;
            r_shift_2   <= 1'b0;
            r_we0       <= 1'b0;
            r_we1       <= 1'b0;
            r_addr0     <= '0;
            r_addr1     <= '0;
            r_data0     <= '0;
            r_data1     <= '0;
            r_flush     <= 1'b0;
            r_redirect  <= '0;
            r_exception <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift;
            r_shift_2   <= w_shift_2;
            r_we0       <= w_we0;
            r_we1       <= w_we1;
            r_addr0     <= w_addr0;
            r_addr1     <= w_addr1;
            r_data0     <= w_data0;
            r_data1     <= w_data1;
            r_flush     <= w_flush;
            r_redirect  <= w_redirect;
            r_exception <= w_exception;
            r_count     <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift      = 1'b0;
        w_shift_2    = 1'b0;
        w_we0        = 1'b0;
        w_we1        = 1'b0;
        w_addr0      = '0;
        w_addr1      = '0;
        w_data0      = '0;
        w_data1      = '0;
        w_flush      = 1'b0;
        w_redirect   = '0;
        w_exception  = 1'b0;
        w_count_next = r_count;

        case (r_state)
            ST_RUN: begin
                if (w_width == RW_TWO) begin
                    w_shift_2    = 1'b1;
                    w_we0        = rob.head0_dest_valid_in;
                    w_we1        = rob.head1_dest_valid_in;
                    w_count_next = rob_count_next(r_count, 2'd2);
                    w_state_next = ST_WAIT;
                end else if (w_width == RW_ONE) begin
                    w_shift      = 1'b1;
                    w_count_next = rob_count_next(r_count, 2'd1);
                    if (w_head0_fault) begin
                        // Exception wins over mispredict: no write, vector 0.
                        w_flush      = 1'b1;
                        w_exception  = rob.head0_exception_in;
                        w_we0        = rob.head0_dest_valid_in & ~rob.head0_exception_in;
                        w_redirect   = rob.head0_exception_in ? '0 : rob.head0_target_in;
                        w_state_next = ST_FLUSH;
                    end else begin
                        w_we0        = rob.head0_dest_valid_in;
                        w_state_next = ST_WAIT;
                    end
                end
                if (w_we0) begin
                    w_addr0 = rob.head0_dest_in;
                    w_data0 = rob.head0_data_in;
                end
                if (w_we1) begin
                    w_addr1 = rob.head1_dest_in;
                    w_data1 = rob.head1_data_in;
                end
            end
            ST_WAIT: begin
                w_state_next = ST_RUN;
            end
            ST_FLUSH: begin
                if (rob.rob_status_in == '0) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    assign rob.reorder_buffer_shift_out   = r_shift;
    assign rob.reorder_buffer_shift_2_out = r_shift_2;
    assign rob.rf_we0_out                 = r_we0;
    assign rob.rf_we1_out                 = r_we1;
    assign rob.rf_addr0_out               = r_addr0;
    assign rob.rf_addr1_out               = r_addr1;
    assign rob.rf_data0_out               = r_data0;
    assign rob.rf_data1_out               = r_data1;
    assign rob.flush_out                  = r_flush;
    assign rob.redirect_pc_out            = r_redirect;
    assign rob.exception_out              = r_exception;
    assign rob.retire_count_out           = r_count;

endmodule

// File: tb/tb_reorder_buffer_retire_ctrl.sv
// Scoreboard bench for the ROB retire controller: expectations queued per decision, compared a cycle later.
module tb_reorder_buffer_retire_ctrl;
    import reorder_buffer_retire_ctrl_pkg::*;

    typedef struct packed {
        logic        sh;
        logic        sh2;
        logic        we0;
        logic        we1;
        logic        fl;
        logic        ex;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] rpc;
        logic [31:0] cnt;
    } exp_t;

    logic clk_in = 1'b0;
    logic reset_in = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t e;
    logic [31:0] cnt_m = 32'd0;

    reorder_buffer_retire_ctrl_if bus ();

    reorder_buffer_retire_ctrl dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .rob      (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_h0(input logic rdy, input logic dv, input logic exc, input logic mis,
                          input logic [3:0] dest, input logic [31:0] data,
                          input logic [31:0] pc, input logic [31:0] tgt);
        bus.head0_ready_in      = rdy;
        bus.head0_dest_valid_in = dv;
        bus.head0_exception_in  = exc;
        bus.head0_mispredict_in = mis;
        bus.head0_dest_in       = dest;
        bus.head0_data_in       = data;
        bus.head0_pc_in         = pc;
        bus.head0_target_in     = tgt;
    endtask

    task automatic set_h1(input logic rdy, input logic dv, input logic exc, input logic mis,
                          input logic [3:0] dest, input logic [31:0] data,
                          input logic [31:0] pc, input logic [31:0] tgt);
        bus.head1_ready_in      = rdy;
        bus.head1_dest_valid_in = dv;
        bus.head1_exception_in  = exc;
        bus.head1_mispredict_in = mis;
        bus.head1_dest_in       = dest;
        bus.head1_data_in       = data;
        bus.head1_pc_in         = pc;
        bus.head1_target_in     = tgt;
    endtask

    task automatic exp_idle();
        e = '0;
        e.cnt = cnt_m;
    endtask

    task automatic compare_head(input string tag);
        exp_t x;
        x = q.pop_front();
        chk({tag, ".shift"},   32'(bus.reorder_buffer_shift_out),   32'(x.sh));
        chk({tag, ".shift2"},  32'(bus.reorder_buffer_shift_2_out), 32'(x.sh2));
        chk({tag, ".we0"},     32'(bus.rf_we0_out),                 32'(x.we0));
        chk({tag, ".we1"},     32'(bus.rf_we1_out),                 32'(x.we1));
        chk({tag, ".addr0"},   32'(bus.rf_addr0_out),               32'(x.a0));
        chk({tag, ".addr1"},   32'(bus.rf_addr1_out),               32'(x.a1));
        chk({tag, ".data0"},   bus.rf_data0_out,                    x.d0);
        chk({tag, ".data1"},   bus.rf_data1_out,                    x.d1);
        chk({tag, ".flush"},   32'(bus.flush_out),                  32'(x.fl));
        chk({tag, ".exc"},     32'(bus.exception_out),              32'(x.ex));
        chk({tag, ".redir"},   bus.redirect_pc_out,                 x.rpc);
        chk({tag, ".count"},   bus.retire_count_out,                x.cnt);
    endtask

    // Queue the current expectation, let the DUT decide on this cycle's inputs, compare after the edge.
    task automatic tick(input string tag);
        q.push_back(e);
        @(posedge clk_in);
        #1;
        compare_head(tag);
    endtask

    initial begin
        bus.rob_status_in = '0;
        set_h0(0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0);
        set_h1(0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk_in);
        #1;
        exp_idle();
        q.push_back(e);
        compare_head("reset");
        reset_in = 1'b0;

        // Dual retire, then WAIT bubble
        bus.rob_status_in = 4'd2;
        set_h0(1, 1, 0, 0, 4'd3, 32'hAAAA_0001, 32'h10, 32'h0);
        set_h1(1, 1, 0, 0, 4'd5, 32'hBBBB_0002, 32'h14, 32'h0);
        cnt_m = 32'd2; exp_idle();
        e.sh2 = 1; e.we0 = 1; e.a0 = 4'd3; e.d0 = 32'hAAAA_0001;
        e.we1 = 1; e.a1 = 4'd5; e.d1 = 32'hBBBB_0002;
        tick("dual");
        exp_idle(); tick("dual_wait");

        // Only one entry present
        bus.rob_status_in = 4'd1;
        cnt_m = 32'd3; exp_idle();
        e.sh = 1; e.we0 = 1; e.a0 = 4'd3; e.d0 = 32'hAAAA_0001;
        tick("single");
        exp_idle(); tick("single_wait");

        // Empty ROB with a stale ready head
        bus.rob_status_in = 4'd0;
        exp_idle(); tick("empty0");
        exp_idle(); tick("empty1");

        // Mispredict without destination, then hold in FLUSH while ROB non-empty
        bus.rob_status_in = 4'd3;
        set_h0(1, 0, 0, 1, 4'd6, 32'h0000_0066, 32'h80, 32'h0000_0100);
        cnt_m = 32'd4; exp_idle();
        e.sh = 1; e.fl = 1; e.rpc = 32'h0000_0100;
        tick("mispred");
        set_h0(1, 1, 0, 0, 4'd3, 32'hAAAA_0001, 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) begin
            exp_idle(); tick("flush_hold");
        end
        bus.rob_status_in = 4'd0;
        exp_idle(); tick("flush_exit");
        bus.rob_status_in = 4'd2;
        cnt_m = 32'd6; exp_idle();
        e.sh2 = 1; e.we0 = 1; e.a0 = 4'd3; e.d0 = 32'hAAAA_0001;
        e.we1 = 1; e.a1 = 4'd5; e.d1 = 32'hBBBB_0002;
        tick("after_flush");
        exp_idle(); tick("after_flush_wait");

        // Mispredict that still writes its destination
        bus.rob_status_in = 4'd1;
        set_h0(1, 1, 0, 1, 4'd2, 32'h0000_DDDD, 32'h90, 32'h0000_0300);
        cnt_m = 32'd7; exp_idle();
        e.sh = 1; e.we0 = 1; e.a0 = 4'd2; e.d0 = 32'h0000_DDDD; e.fl = 1; e.rpc = 32'h0000_0300;
        tick("mispred_dv");
        bus.rob_status_in = 4'd0;
        exp_idle(); tick("mispred_dv_exit");

        // head0 good, head1 faulting: head0 retires alone, head1 faults next decision
        bus.rob_status_in = 4'd2;
        set_h0(1, 1, 0, 0, 4'd7, 32'hCCCC_0003, 32'h40, 32'h0);
        set_h1(1, 1, 1, 0, 4'd9, 32'hEEEE_0004, 32'h44, 32'h0000_0500);
        cnt_m = 32'd8; exp_idle();
        e.sh = 1; e.we0 = 1; e.a0 = 4'd7; e.d0 = 32'hCCCC_0003;
        tick("h1_fault");
        exp_idle(); tick("h1_fault_wait");
        bus.rob_status_in = 4'd1;
        set_h0(1, 1, 1, 0, 4'd9, 32'hEEEE_0004, 32'h44, 32'h0000_0500);
        cnt_m = 32'd9; exp_idle();
        e.sh = 1; e.fl = 1; e.ex = 1;
        tick("exception");
        bus.rob_status_in = 4'd0;
        exp_idle(); tick("exception_exit");

        // Exception and mispredict together: exception wins
        bus.rob_status_in = 4'd1;
        set_h0(1, 1, 1, 1, 4'd1, 32'hFFFF_0005, 32'h48, 32'h0000_0600);
        cnt_m = 32'd10; exp_idle();
        e.sh = 1; e.fl = 1; e.ex = 1;
        tick("exc_and_mis");
        bus.rob_status_in = 4'd0;
        exp_idle(); tick("exc_and_mis_exit");

        // head1 not ready, head0 without destination
        bus.rob_status_in = 4'd2;
        set_h0(1, 0, 0, 0, 4'd4, 32'h1234_5678, 32'h50, 32'h0);
        set_h1(0, 1, 0, 0, 4'd5, 32'hBBBB_0002, 32'h54, 32'h0);
        cnt_m = 32'd11; exp_idle();
        e.sh = 1;
        tick("h1_not_ready");
        exp_idle(); tick("h1_not_ready_wait");

        // head0 not ready: nothing for 10 cycles
        bus.rob_status_in = 4'd4;
        set_h0(0, 1, 0, 0, 4'd3, 32'hAAAA_0001, 32'h10, 32'h0);
        set_h1(1, 1, 0, 0, 4'd5, 32'hBBBB_0002, 32'h14, 32'h0);
        for (int i = 0; i < 10; i++) begin
            exp_idle(); tick("stall");
        end

        // Reset while in FLUSH
        bus.rob_status_in = 4'd3;
        set_h0(1, 0, 0, 1, 4'd6, 32'h0000_0066, 32'h80, 32'h0000_0700);
        cnt_m = 32'd12; exp_idle();
        e.sh = 1; e.fl = 1; e.rpc = 32'h0000_0700;
        tick("pre_reset_flush");
        reset_in = 1'b1;
        cnt_m = 32'd0; exp_idle(); tick("reset_in_flush");
        reset_in = 1'b0;
        bus.rob_status_in = 4'd2;
        set_h0(1, 1, 0, 0, 4'd3, 32'hAAAA_0001, 32'h10, 32'h0);
        cnt_m = 32'd2; exp_idle();
        e.sh2 = 1; e.we0 = 1; e.a0 = 4'd3; e.d0 = 32'hAAAA_0001;
        e.we1 = 1; e.a1 = 4'd5; e.d1 = 32'hBBBB_0002;
        tick("run_after_reset");

        // Reset coinciding with an eligible decision drops it
        reset_in = 1'b1;
        cnt_m = 32'd0; exp_idle(); tick("reset_drop");
        reset_in = 1'b0;
        cnt_m = 32'd2; exp_idle();
        e.sh2 = 1; e.we0 = 1; e.a0 = 4'd3; e.d0 = 32'hAAAA_0001;
        e.we1 = 1; e.a1 = 4'd5; e.d1 = 32'hBBBB_0002;
        tick("run_after_drop");

        chk("count_wrap2", rob_count_next(32'hFFFF_FFFF, 2'd2), 32'd1);
        chk("count_wrap1", rob_count_next(32'hFFFF_FFFF, 2'd1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
